axi4lite_mem_slave: RTL and testbench
=====================================

Name: axi4lite_mem_slave

Overview:
- AXI4-Lite responder (slave) backed by an internal 64-bit-wide memory array.
- Used as the memory-side endpoint for the core's bus interface unit in simulation and FPGA bring-up.
- Serves 8-byte single-beat reads and writes with per-byte strobes, configurable read latency, and SLVERR for out-of-range addresses.
- Read and write channels are independent and may be active concurrently.

Parameters:
- BASE_ADDR, 64'h8000_0000, byte address of memory word 0.
- DEPTH, 4096, number of 64-bit words (power of two, >= 8).
- RD_LAT, 2, extra cycles between AR acceptance and rvalid_o (0..15).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- awvalid_i  input  1  write address valid
- awready_o  output  1  write address ready
- awaddr_i  input  64  write byte address
- awprot_i  input  1  protection, ignored
- wvalid_i  input  1  write data valid
- wready_o  output  1  write data ready
- wdata_i  input  64  write data
- wstrb_i  input  8  byte strobes; bit k enables wdata_i[8k+:8]
- bvalid_o  output  1  write response valid
- bready_i  input  1  write response ready
- bresp_o  output  2  2'b00 OKAY, 2'b10 SLVERR
- arvalid_i  input  1  read address valid
- arready_o  output  1  read address ready
- araddr_i  input  64  read byte address
- arprot_i  input  1  protection, ignored
- rvalid_o  output  1  read data valid
- rready_i  input  1  read data ready
- rdata_o  output  64  read data
- rresp_o  output  2  2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous, active-low.
- Values while reset is asserted:
  - awready_o=1, wready_o=1, arready_o=1
  - bvalid_o=0, rvalid_o=0
  - bresp_o=0, rresp_o=0, rdata_o=0
  - both FSMs in IDLE, held flags cleared
  - memory array is not reset
- Reset asserted mid-transaction aborts it silently. No response is issued afterwards. A write whose commit edge has already passed stays in memory.
- Address decode:
  - off = addr - BASE_ADDR, 64-bit unsigned.
  - In range iff off < DEPTH*8. Index = off[log2(DEPTH)+2:3].
  - addr[2:0] is ignored, so unaligned addresses map to the containing word.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE: awready_o = !aw_held and wready_o = !w_held.
  - An AW handshake latches awaddr_i and sets aw_held. A W handshake latches wdata_i/wstrb_i and sets w_held. AW and W may arrive in either order or on the same edge.
  - Commit edge: the edge where both are held (including either or both arriving on that edge).
    - In range: write the strobed bytes into mem[index]; bytes with strobe 0 are unchanged; bresp=OKAY.
    - Out of range: no write; bresp=SLVERR.
    - Go to W_RESP and clear both held flags.
  - In W_RESP: bvalid_o=1, awready_o=0, wready_o=0, and bresp_o is stable. On bvalid_o & bready_i go to W_IDLE.
  - Latency: bvalid_o rises 1 cycle after the commit edge. Minimum is one write per 2 cycles.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - In R_IDLE: arready_o=1. An AR handshake latches the address and loads the counter with RD_LAT.
    - RD_LAT=0: go to R_RESP.
    - Otherwise: go to R_WAIT.
  - In R_WAIT: arready_o=0. The counter decrements each cycle. At 1, go to R_RESP on the next edge.
  - Data capture: on the edge entering R_RESP, rdata_o = mem[index] and rresp=OKAY. Out of range gives rdata_o=0 and rresp=SLVERR.
  - rvalid_o rises exactly RD_LAT+1 cycles after the AR handshake edge.
  - In R_RESP: rvalid_o=1, arready_o=0. rdata_o and rresp_o stay stable until rvalid_o & rready_i, then go to R_IDLE.
  - Back-to-back: arready_o is 1 in the cycle after the R handshake.
- Read/write collision: if a write commit and a read capture hit the same word on the same edge, the read returns the pre-write data. A read captured on any later edge sees the new data.
- rvalid_o and bvalid_o never drop without their handshake. They do not depend combinationally on bready_i/rready_i.
- awprot_i and arprot_i are ignored.

Test Plan:
- Full write then read: AW and W together, addr=BASE+0x10, data=64'h1122334455667788, strb=8'hFF → bvalid_o 1 cycle later, bresp_o=0. Then AR to the same address with RD_LAT=2 → rvalid_o 3 cycles after AR, rdata_o=64'h1122334455667788.
- Partial strobe: write 64'hFFFF_FFFF_FFFF_FFFF to BASE, then 64'h0 with strb=8'h0F → read returns 64'hFFFF_FFFF_0000_0000.
- Split write channels: W at cycle 0, AW at cycle 3 → wready_o=0 during cycles 1-3, commit at cycle 3, bvalid_o at cycle 4.
- Out of range: AR to BASE+DEPTH*8 → rresp_o=2'b10, rdata_o=0. Write to BASE-8 → bresp_o=2'b10, memory unchanged.
- Backpressure: hold rready_i=0 for 5 cycles → rvalid_o and rdata_o stable, arready_o=0. Same for bready_i=0 → awready_o=0 and wready_o=0.
- Reset mid-read: assert rst_n low during R_WAIT → rvalid_o=0 and arready_o=1 after release, no stale response.

Source files
------------

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite memory responder: 64-bit word array with byte strobes, fixed read latency
// and SLVERR for addresses outside [BASE_ADDR, BASE_ADDR + DEPTH*8).
module axi4lite_mem_slave #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [63:0] awaddr_i,
    input  logic        awprot_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o,
    input  logic        arvalid_i,
    output logic        arready_o,
    input  logic [63:0] araddr_i,
    input  logic        arprot_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [63:0] rdata_o,
    output logic [1:0]  rresp_o
);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [63:0] SPAN      = 64'(DEPTH) << 3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    logic [63:0] mem [DEPTH];

    w_state_t           w_state, w_state_nxt;
    logic               aw_held, w_held, aw_hs, w_hs, commit;
    logic [63:0]        aw_addr_q, w_data_q;
    logic [7:0]         w_strb_q;
    logic [63:0]        wr_addr, wr_data, wr_off;
    logic [7:0]         wr_strb;
    logic               wr_hit;
    logic [IDX_W-1:0]   wr_idx;

    r_state_t           r_state, r_state_nxt;
    logic               ar_hs, capture;
    logic [63:0]        ar_addr_q, rd_addr, rd_off;
    logic [3:0]         rd_cnt;
    logic               rd_hit;
    logic [IDX_W-1:0]   rd_idx;

    wire unused_prot = &{1'b0, awprot_i, arprot_i};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = w_state;
        awready_o   = 1'b0;
        wready_o    = 1'b0;
        bvalid_o    = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        commit      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_o = !aw_held;
                wready_o  = !w_held;
                aw_hs     = awvalid_i && !aw_held;
                w_hs      = wvalid_i && !w_held;
                commit    = (aw_held || aw_hs) && (w_held || w_hs);
                if (commit) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // A held beat wins; otherwise the beat arriving on the commit edge is used directly.
    assign wr_addr = aw_held ? aw_addr_q : awaddr_i;
    assign wr_data = w_held ? w_data_q : wdata_i;
    assign wr_strb = w_held ? w_strb_q : wstrb_i;
    assign wr_off  = wr_addr - BASE_ADDR;
    assign wr_hit  = wr_off < SPAN;
    assign wr_idx  = IDX_W'(wr_off >> 3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_o   <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_o <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= awaddr_i;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= wdata_i;
                    w_strb_q <= wstrb_i;
                end
            end
        end
    end

    // NOTE: the array has no reset; contents survive rst_n and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n && commit && wr_hit) begin
            for (int k = 0; k < 8; k++) begin
                if (wr_strb[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        arready_o   = 1'b0;
        rvalid_o    = 1'b0;
        ar_hs       = 1'b0;
        capture     = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_o = 1'b1;
                ar_hs     = arvalid_i;
                if (ar_hs) begin
                    r_state_nxt = (RD_LAT == 0) ? R_RESP : R_WAIT;
                    capture     = (RD_LAT == 0);
                end
            end
            R_WAIT: begin
                if (rd_cnt == 4'd1) begin
                    r_state_nxt = R_RESP;
                    capture     = 1'b1;
                end
            end
            R_RESP: begin
                rvalid_o = 1'b1;
                if (rready_i) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign rd_addr = (r_state == R_IDLE) ? araddr_i : ar_addr_q;
    assign rd_off  = rd_addr - BASE_ADDR;
    assign rd_hit  = rd_off < SPAN;
    assign rd_idx  = IDX_W'(rd_off >> 3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            rd_cnt    <= '0;
            ar_addr_q <= '0;
            rdata_o   <= '0;
            rresp_o   <= RESP_OKAY;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                ar_addr_q <= araddr_i;
                rd_cnt    <= 4'(RD_LAT);
            end else if (r_state == R_WAIT) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            // NOTE: non-blocking capture samples mem before a same-edge write lands, giving pre-write data.
            if (capture) begin
                rdata_o <= rd_hit ? mem[rd_idx] : '0;
                rresp_o <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// Randomized self-checking bench for axi4lite_mem_slave against an array-based memory model.
module tb_axi4lite_mem_slave;
    localparam logic [63:0] BASE   = 64'h8000_0000;
    localparam int          DEPTH  = 64;
    localparam int          RD_LAT = 2;
    localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'd8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        awvalid_i = 0, awready_o, awprot_i = 0;
    logic [63:0] awaddr_i = '0;
    logic        wvalid_i = 0, wready_o;
    logic [63:0] wdata_i = '0;
    logic [7:0]  wstrb_i = '0;
    logic        bvalid_o, bready_i = 0;
    logic [1:0]  bresp_o;
    logic        arvalid_i = 0, arready_o, arprot_i = 0;
    logic [63:0] araddr_i = '0;
    logic        rvalid_o, rready_i = 0;
    logic [63:0] rdata_o;
    logic [1:0]  rresp_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] ref_mem [DEPTH];

    axi4lite_mem_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awprot_i(awprot_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arprot_i(arprot_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Model: byte address -> word slot in a flat array, SLVERR outside the window.
    function automatic logic ref_in_range(input logic [63:0] addr);
        return (addr - BASE) < SPAN;
    endfunction

    function automatic int ref_index(input logic [63:0] addr);
        return int'((addr - BASE) / 64'd8);
    endfunction

    task automatic ref_write(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, output logic [1:0] resp);
        logic [63:0] mask;
        resp = 2'b10;
        if (ref_in_range(addr)) begin
            for (int k = 0; k < 8; k++) mask[8*k +: 8] = {8{strb[k]}};
            ref_mem[ref_index(addr)] = (ref_mem[ref_index(addr)] & ~mask) | (data & mask);
            resp = 2'b00;
        end
    endtask

    task automatic ref_read(input logic [63:0] addr, output logic [63:0] data, output logic [1:0] resp);
        data = '0;
        resp = 2'b10;
        if (ref_in_range(addr)) begin
            data = ref_mem[ref_index(addr)];
            resp = 2'b00;
        end
    endtask

    // AW and W presented together; lat = cycles from commit edge to bvalid seen.
    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            output logic [1:0] resp, output int lat);
        int guard;
        logic a_rdy, w_rdy;
        awaddr_i = addr; wdata_i = data; wstrb_i = strb;
        awvalid_i = 1; wvalid_i = 1;
        guard = 0;
        while ((awvalid_i || wvalid_i) && guard < 20) begin
            a_rdy = awready_o;
            w_rdy = wready_o;
            tick();
            guard++;
            if (a_rdy) awvalid_i = 0;
            if (w_rdy) wvalid_i = 0;
        end
        if (guard >= 20) begin
            n_cmp++; n_err++;
            $display("FAIL write_accept_timeout: awvalid=%0b wvalid=%0b still pending, required accepted", awvalid_i, wvalid_i);
            awvalid_i = 0; wvalid_i = 0;
        end
        lat = 1;
        while (!bvalid_o && lat < 20) begin tick(); lat++; end
        resp = bresp_o;
        bready_i = 1; tick(); bready_i = 0;
    endtask

    // lat = cycles from AR handshake edge to rvalid seen.
    task automatic do_read(input logic [63:0] addr, output logic [63:0] data,
                           output logic [1:0] resp, output int lat);
        int guard;
        araddr_i = addr; arvalid_i = 1;
        guard = 0;
        while (!arready_o && guard < 20) begin tick(); guard++; end
        tick();
        arvalid_i = 0;
        lat = 1;
        while (!rvalid_o && lat < 40) begin tick(); lat++; end
        data = rdata_o;
        resp = rresp_o;
        rready_i = 1; tick(); rready_i = 0;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        n_cmp++;
        if ({awready_o, wready_o, arready_o, bvalid_o, rvalid_o} !== 5'b11100) begin
            n_err++;
            $display("FAIL reset_handshake: got %b required 11100", {awready_o, wready_o, arready_o, bvalid_o, rvalid_o});
        end
        n_cmp++;
        if ({bresp_o, rresp_o, rdata_o} !== 68'h0) begin
            n_err++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h required all zero", bresp_o, rresp_o, rdata_o);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_fill;
        logic [1:0] resp, exp_resp;
        int lat;
        logic [63:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = rand64();
            do_write(BASE + 64'(i) * 8, d, 8'hFF, resp, lat);
            ref_write(BASE + 64'(i) * 8, d, 8'hFF, exp_resp);
            n_cmp++;
            if (resp !== exp_resp || lat !== 1) begin
                n_err++;
                $display("FAIL fill_write[%0d]: bresp=%b lat=%0d required bresp=%b lat=1", i, resp, lat, exp_resp);
            end
        end
    endtask

    task automatic test_write_read;
        logic [1:0] resp, exp_resp;
        logic [63:0] d;
        int lat;
        do_write(BASE + 64'h10, 64'h1122334455667788, 8'hFF, resp, lat);
        ref_write(BASE + 64'h10, 64'h1122334455667788, 8'hFF, exp_resp);
        n_cmp++;
        if (resp !== 2'b00 || lat !== 1) begin
            n_err++;
            $display("FAIL basic_write: bresp=%b lat=%0d required bresp=00 lat=1", resp, lat);
        end
        do_read(BASE + 64'h10, d, resp, lat);
        n_cmp++;
        if (d !== 64'h1122334455667788 || resp !== 2'b00 || lat !== RD_LAT + 1) begin
            n_err++;
            $display("FAIL basic_read: rdata=%h rresp=%b lat=%0d required 1122334455667788/00/%0d", d, resp, lat, RD_LAT + 1);
        end
    endtask

    task automatic test_partial_strobe;
        logic [1:0] resp, exp_resp;
        logic [63:0] d;
        int lat;
        do_write(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, lat);
        ref_write(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, exp_resp);
        do_write(BASE, 64'h0, 8'h0F, resp, lat);
        ref_write(BASE, 64'h0, 8'h0F, exp_resp);
        do_read(BASE, d, resp, lat);
        n_cmp++;
        if (d !== 64'hFFFF_FFFF_0000_0000) begin
            n_err++;
            $display("FAIL partial_strobe: rdata=%h required ffffffff00000000", d);
        end
        // Random strobe masks on an unaligned address of a random word.
        for (int i = 0; i < 6; i++) begin
            logic [63:0] a, nd, exp_d;
            logic [7:0] s;
            logic [1:0] exp_r;
            a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8 + 64'($urandom_range(0, 7));
            nd = rand64();
            s = 8'($urandom);
            do_write(a, nd, s, resp, lat);
            ref_write(a, nd, s, exp_resp);
            do_read(a, d, resp, lat);
            ref_read(a, exp_d, exp_r);
            n_cmp++;
            if (d !== exp_d || resp !== exp_r) begin
                n_err++;
                $display("FAIL strobe_rand[%0d]: rdata=%h rresp=%b required %h/%b (strb=%h)", i, d, resp, exp_d, exp_r, s);
            end
        end
    endtask

    task automatic test_split_write;
        logic [1:0] resp, exp_resp;
        logic [63:0] d, a, nd;
        int lat;
        a = BASE + 64'h28;
        nd = rand64();
        wdata_i = nd; wstrb_i = 8'hFF; wvalid_i = 1;
        tick();
        wvalid_i = 0;
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({wready_o, awready_o, bvalid_o} !== 3'b010) begin
                n_err++;
                $display("FAIL split_wait[c%0d]: wready/awready/bvalid=%b required 010", c, {wready_o, awready_o, bvalid_o});
            end
            if (c == 3) begin awaddr_i = a; awvalid_i = 1; end
            tick();
        end
        awvalid_i = 0;
        ref_write(a, nd, 8'hFF, exp_resp);
        n_cmp++;
        if (bvalid_o !== 1'b1 || bresp_o !== 2'b00) begin
            n_err++;
            $display("FAIL split_bvalid: bvalid=%b bresp=%b required 1/00", bvalid_o, bresp_o);
        end
        bready_i = 1; tick(); bready_i = 0;
        // AW first, W two cycles later.
        a = BASE + 64'h30;
        nd = rand64();
        awaddr_i = a; awvalid_i = 1;
        tick();
        awvalid_i = 0;
        tick();
        n_cmp++;
        if ({awready_o, wready_o, bvalid_o} !== 3'b010) begin
            n_err++;
            $display("FAIL split_aw_wait: awready/wready/bvalid=%b required 010", {awready_o, wready_o, bvalid_o});
        end
        wdata_i = nd; wstrb_i = 8'hF0; wvalid_i = 1;
        tick();
        wvalid_i = 0;
        ref_write(a, nd, 8'hF0, exp_resp);
        n_cmp++;
        if (bvalid_o !== 1'b1) begin
            n_err++;
            $display("FAIL split_aw_bvalid: bvalid=%b required 1", bvalid_o);
        end
        bready_i = 1; tick(); bready_i = 0;
        do_read(BASE + 64'h28, d, resp, lat);
        n_cmp++;
        if (d !== ref_mem[5]) begin
            n_err++;
            $display("FAIL split_readback_w_first: rdata=%h required %h", d, ref_mem[5]);
        end
        do_read(a, d, resp, lat);
        n_cmp++;
        if (d !== ref_mem[6]) begin
            n_err++;
            $display("FAIL split_readback_aw_first: rdata=%h required %h", d, ref_mem[6]);
        end
    endtask

    task automatic test_out_of_range;
        logic [1:0] resp, exp_resp;
        logic [63:0] d, first, last;
        int lat;
        do_read(BASE + SPAN, d, resp, lat);
        n_cmp++;
        if (d !== 64'h0 || resp !== 2'b10 || lat !== RD_LAT + 1) begin
            n_err++;
            $display("FAIL oor_read_top: rdata=%h rresp=%b lat=%0d required 0/10/%0d", d, resp, lat, RD_LAT + 1);
        end
        do_read(BASE + SPAN - 1, d, resp, lat);
        n_cmp++;
        if (d !== ref_mem[DEPTH - 1] || resp !== 2'b00) begin
            n_err++;
            $display("FAIL last_word_read: rdata=%h rresp=%b required %h/00", d, resp, ref_mem[DEPTH - 1]);
        end
        first = ref_mem[0];
        last  = ref_mem[DEPTH - 1];
        do_write(BASE - 8, ~last, 8'hFF, resp, lat);
        ref_write(BASE - 8, ~last, 8'hFF, exp_resp);
        n_cmp++;
        if (resp !== 2'b10 || lat !== 1) begin
            n_err++;
            $display("FAIL oor_write_below: bresp=%b lat=%0d required 10/1", resp, lat);
        end
        do_write(BASE + SPAN, ~first, 8'hFF, resp, lat);
        n_cmp++;
        if (resp !== 2'b10) begin
            n_err++;
            $display("FAIL oor_write_top: bresp=%b required 10", resp);
        end
        do_read(BASE + SPAN - 8, d, resp, lat);
        n_cmp++;
        if (d !== last) begin
            n_err++;
            $display("FAIL oor_last_unchanged: rdata=%h required %h", d, last);
        end
        do_read(BASE, d, resp, lat);
        n_cmp++;
        if (d !== first) begin
            n_err++;
            $display("FAIL oor_first_unchanged: rdata=%h required %h", d, first);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] exp_resp;
        logic [63:0] a, nd;
        int guard;
        a = BASE + 64'(($urandom_range(0, DEPTH - 1))) * 8;
        araddr_i = a; arvalid_i = 1;
        tick();
        arvalid_i = 0;
        guard = 0;
        while (!rvalid_o && guard < 20) begin tick(); guard++; end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (rvalid_o !== 1'b1 || arready_o !== 1'b0 || rdata_o !== ref_mem[ref_index(a)] || rresp_o !== 2'b00) begin
                n_err++;
                $display("FAIL read_stall[c%0d]: rvalid=%b arready=%b rdata=%h rresp=%b required 1/0/%h/00",
                         c, rvalid_o, arready_o, rdata_o, rresp_o, ref_mem[ref_index(a)]);
            end
            tick();
        end
        rready_i = 1; tick(); rready_i = 0;
        nd = rand64();
        awaddr_i = a; wdata_i = nd; wstrb_i = 8'hFF; awvalid_i = 1; wvalid_i = 1;
        tick();
        awvalid_i = 0; wvalid_i = 0;
        ref_write(a, nd, 8'hFF, exp_resp);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({bvalid_o, awready_o, wready_o, bresp_o} !== 5'b10000) begin
                n_err++;
                $display("FAIL write_stall[c%0d]: bvalid/awready/wready/bresp=%b required 10000",
                         c, {bvalid_o, awready_o, wready_o, bresp_o});
            end
            tick();
        end
        bready_i = 1; tick(); bready_i = 0;
    endtask

    task automatic test_back_to_back;
        logic [1:0] resp, exp_r;
        logic [63:0] d, exp_d, a;
        int lat;
        for (int i = 0; i < 3; i++) begin
            a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8;
            do_read(a, d, resp, lat);
            ref_read(a, exp_d, exp_r);
            n_cmp++;
            if (arready_o !== 1'b1 || rvalid_o !== 1'b0 || d !== exp_d) begin
                n_err++;
                $display("FAIL b2b_read[%0d]: arready=%b rvalid=%b rdata=%h required 1/0/%h", i, arready_o, rvalid_o, d, exp_d);
            end
            do_write(a, ~d, 8'hFF, resp, lat);
            ref_write(a, ~d, 8'hFF, exp_r);
            n_cmp++;
            if (awready_o !== 1'b1 || wready_o !== 1'b1 || bvalid_o !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_write[%0d]: awready=%b wready=%b bvalid=%b required 1/1/0", i, awready_o, wready_o, bvalid_o);
            end
        end
    endtask

    task automatic test_collision;
        logic [1:0] resp, exp_resp;
        logic [63:0] a, old_d, nd, d;
        int lat;
        a = BASE + 64'h40;
        old_d = ref_mem[8];
        nd = ~old_d ^ 64'h5A5A;
        araddr_i = a; arvalid_i = 1;
        tick();
        arvalid_i = 0;
        repeat (RD_LAT - 1) tick();
        awaddr_i = a; wdata_i = nd; wstrb_i = 8'hFF; awvalid_i = 1; wvalid_i = 1;
        tick();
        awvalid_i = 0; wvalid_i = 0;
        n_cmp++;
        if (rvalid_o !== 1'b1 || bvalid_o !== 1'b1 || rdata_o !== old_d) begin
            n_err++;
            $display("FAIL collision_old_data: rvalid=%b bvalid=%b rdata=%h required 1/1/%h", rvalid_o, bvalid_o, rdata_o, old_d);
        end
        ref_write(a, nd, 8'hFF, exp_resp);
        rready_i = 1; bready_i = 1;
        tick();
        rready_i = 0; bready_i = 0;
        do_read(a, d, resp, lat);
        n_cmp++;
        if (d !== nd) begin
            n_err++;
            $display("FAIL collision_new_data: rdata=%h required %h", d, nd);
        end
    endtask

    task automatic test_random;
        logic [1:0] resp, exp_r;
        logic [63:0] a, d, exp_d;
        logic [7:0] s;
        int lat;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? BASE + SPAN + 64'($urandom_range(0, 100)) * 8
                                                : BASE - 64'($urandom_range(1, 100)) * 8;
            end else begin
                a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8 + 64'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 1) begin
                d = rand64();
                s = 8'($urandom);
                do_write(a, d, s, resp, lat);
                ref_write(a, d, s, exp_r);
                n_cmp++;
                if (resp !== exp_r || lat !== 1) begin
                    n_err++;
                    $display("FAIL rand_write[%0d]: addr=%h bresp=%b lat=%0d required %b/1", i, a, resp, lat, exp_r);
                end
            end else begin
                do_read(a, d, resp, lat);
                ref_read(a, exp_d, exp_r);
                n_cmp++;
                if (d !== exp_d || resp !== exp_r || lat !== RD_LAT + 1) begin
                    n_err++;
                    $display("FAIL rand_read[%0d]: addr=%h rdata=%h rresp=%b lat=%0d required %h/%b/%0d",
                             i, a, d, resp, lat, exp_d, exp_r, RD_LAT + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic [1:0] resp;
        logic [63:0] d;
        int lat;
        araddr_i = BASE + 64'h18; arvalid_i = 1;
        tick();
        arvalid_i = 0;
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if (arready_o !== 1'b1 || rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: arready=%b rvalid=%b required 1/0", arready_o, rvalid_o);
        end
        tick();
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if (arready_o !== 1'b1 || rvalid_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_no_stale[c%0d]: arready=%b rvalid=%b required 1/0", c, arready_o, rvalid_o);
            end
        end
        do_read(BASE + 64'h18, d, resp, lat);
        n_cmp++;
        if (d !== ref_mem[3] || resp !== 2'b00 || lat !== RD_LAT + 1) begin
            n_err++;
            $display("FAIL reset_mem_kept: rdata=%h rresp=%b lat=%0d required %h/00/%0d", d, resp, lat, ref_mem[3], RD_LAT + 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_partial_strobe();
        test_split_write();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_collision();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
